// File: rtl/simon_pkg.sv
// Shared types and helpers for the simonSays switch capture front end.
package simon_pkg;

  localparam int unsigned SW_W   = 4;
  localparam int unsigned CODE_W = 2;
  localparam int unsigned ST_W   = 3;

  typedef enum logic [ST_W-1:0] {
    ARM        = 3'd0,
    WAIT_PRESS = 3'd1,
    DEB_PRESS  = 3'd2,
    HELD       = 3'd3,
    DEB_REL    = 3'd4
  } capture_state_t;

  // One-hot switch patterns for each colour
  localparam logic [SW_W-1:0] SW_C0 = 4'b0001;
  localparam logic [SW_W-1:0] SW_C1 = 4'b0010;
  localparam logic [SW_W-1:0] SW_C2 = 4'b0100;
  localparam logic [SW_W-1:0] SW_C3 = 4'b1000;

  // Switch pattern to colour code; inverse of decoder_2_4
  function automatic logic [CODE_W-1:0] encode_onehot(input logic [SW_W-1:0] v);
    logic [CODE_W-1:0] c;
    c = 2'd0;
    case (v)
      SW_C0:   c = 2'd0;
      SW_C1:   c = 2'd1;
      SW_C2:   c = 2'd2;
      SW_C3:   c = 2'd3;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

  // True when exactly one bit is set
  function automatic logic is_onehot(input logic [SW_W-1:0] v);
    return (v != '0) && ((v & (v - SW_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/switch_input_capture_if.sv
// Handshake bundle between the simonSays FSM and the switch capture stage.
interface switch_input_capture_if;
  import simon_pkg::*;

  logic              enable;
  logic [SW_W-1:0]   sw;
  logic [CODE_W-1:0] code_out;
  logic              code_valid;
  logic              multi_err;
  logic              timeout;
  logic              busy;

  // FSM side: drives enable and the raw switches, consumes results
  modport master (
    output enable, sw,
    input  code_out, code_valid, multi_err, timeout, busy
  );

  // Capture stage side
  modport slave (
    input  enable, sw,
    output code_out, code_valid, multi_err, timeout, busy
  );
endinterface

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a saturating stability counter.
module sync_debounce #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] sw_s,
  output logic             stable
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Next-state for synchroniser, history and stability counter
  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
    prev_d = sync_q;
    cnt_d  = cnt_q;
    if (clr || (sync_q != prev_q)) begin
      cnt_d = '0;
    end else if (cnt_q < CW'(DEBOUNCE_CYCLES)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  // Stability only counts for the value currently presented
  assign sw_s   = sync_q;
  assign stable = (cnt_q == CW'(DEBOUNCE_CYCLES)) && (sync_q == prev_q);

endmodule

// File: rtl/switch_input_capture.sv
// Debounced player switch capture: one committed colour code per press/release.
module switch_input_capture
  import simon_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TIMEOUT_CYCLES  = 250000000
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  switch_input_capture_if.slave  bus
);

  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [TCW-1:0] T_MAX  = {TCW{1'b1}};

  localparam logic [ST_W-1:0] S_ARM      = ST_W'(ARM);
  localparam logic [ST_W-1:0] S_WAIT     = ST_W'(WAIT_PRESS);
  localparam logic [ST_W-1:0] S_DEB_PRES = ST_W'(DEB_PRESS);
  localparam logic [ST_W-1:0] S_HELD     = ST_W'(HELD);
  localparam logic [ST_W-1:0] S_DEB_REL  = ST_W'(DEB_REL);

  logic [SW_W-1:0]   sw_s;
  logic              stable;

  logic [ST_W-1:0]   state_q, state_d;
  logic [TCW-1:0]    tcnt_q, tcnt_d;
  logic [SW_W-1:0]   press_q, press_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              merr_q, merr_d;
  logic              tout_q, tout_d;
  logic              busy_q, busy_d;

  sync_debounce #(
    .WIDTH           (SW_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk    (CLOCK_50),
    .rst    (reset),
    .clr    (~bus.enable),
    .d_in   (bus.sw),
    .sw_s   (sw_s),
    .stable (stable)
  );

  // Capture FSM next-state, timeout counter and registered pulse outputs
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    press_d = press_q;
    code_d  = code_q;
    valid_d = 1'b0;
    merr_d  = 1'b0;
    tout_d  = 1'b0;

    if (!bus.enable) begin
      state_d = S_ARM;
      tcnt_d  = '0;
    end else begin
      case (state_q)
        S_ARM: begin
          // A switch left on from the previous round must go off first
          if (stable && (sw_s == '0)) begin
            state_d = S_WAIT;
            tcnt_d  = '0;
          end
        end
        S_WAIT: begin
          if (sw_s != '0) begin
            state_d = S_DEB_PRES;
            tcnt_d  = '0;
          end else if (tcnt_q >= T_LAST) begin
            tout_d  = 1'b1;
            state_d = S_ARM;
            tcnt_d  = '0;
          end else if (tcnt_q != T_MAX) begin
            tcnt_d = tcnt_q + TCW'(1);
          end
        end
        S_DEB_PRES: begin
          if (sw_s == '0) begin
            state_d = S_WAIT;
          end else if (stable) begin
            if (is_onehot(sw_s)) begin
              press_d = sw_s;
              state_d = S_HELD;
            end else begin
              merr_d  = 1'b1;
              state_d = S_ARM;
            end
          end
        end
        S_HELD: begin
          if (sw_s == '0) begin
            state_d = S_DEB_REL;
          end else if (sw_s != press_q) begin
            merr_d  = 1'b1;
            state_d = S_ARM;
          end
        end
        S_DEB_REL: begin
          if (sw_s != '0) begin
            state_d = S_HELD;
          end else if (stable) begin
            code_d  = encode_onehot(press_q);
            valid_d = 1'b1;
            state_d = S_WAIT;
            tcnt_d  = '0;
          end
        end
        default: begin
          state_d = S_ARM;
          tcnt_d  = '0;
        end
      endcase
    end

    busy_d = (state_d != S_ARM) && (state_d != S_WAIT);
  end

  // State and output registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= S_ARM;
      tcnt_q  <= '0;
      press_q <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      merr_q  <= 1'b0;
      tout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      press_q <= press_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      merr_q  <= merr_d;
      tout_q  <= tout_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.code_out   = code_q;
  assign bus.code_valid = valid_q;
  assign bus.multi_err  = merr_q;
  assign bus.timeout    = tout_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_switch_input_capture.sv
// Directed bench for switch_input_capture with short debounce/timeout settings.
module tb_switch_input_capture;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_pass;
  int   n_valid;
  int   n_merr;
  int   n_tout;
  int   n_excl;
  int   last_valid_cyc;
  int   last_tout_cyc;

  switch_input_capture_if bus();

  switch_input_capture #(
    .DEBOUNCE_CYCLES (2),
    .TIMEOUT_CYCLES  (50)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Pulse bookkeeping, sampled away from the active edge
  always @(negedge clk) begin
    if (bus.code_valid === 1'b1) begin
      n_valid++;
      last_valid_cyc = cyc;
    end
    if (bus.multi_err === 1'b1) n_merr++;
    if (bus.timeout === 1'b1) begin
      n_tout++;
      last_tout_cyc = cyc;
    end
    if ((int'(bus.code_valid === 1'b1) + int'(bus.multi_err === 1'b1)
         + int'(bus.timeout === 1'b1)) > 1) n_excl++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold a pattern, release it, and return cycles from release to last commit
  task automatic press_release(input logic [3:0] pat, input int hold, output int lat);
    int rel;
    bus.sw = pat;
    tick(hold);
    bus.sw = 4'b0000;
    rel = cyc;
    tick(10);
    lat = last_valid_cyc - rel;
  endtask

  logic [3:0] pats [4];
  int         codes [4];
  int         v0, m0, t0, lat, rr, ref_cyc;

  initial begin
    cyc = 0; n_chk = 0; n_pass = 0;
    n_valid = 0; n_merr = 0; n_tout = 0; n_excl = 0;
    last_valid_cyc = 0; last_tout_cyc = 0;
    pats[0] = 4'b0100; codes[0] = 2;
    pats[1] = 4'b0001; codes[1] = 0;
    pats[2] = 4'b0010; codes[2] = 1;
    pats[3] = 4'b1000; codes[3] = 3;

    rst = 1'b1;
    bus.enable = 1'b0;
    bus.sw = 4'b0000;
    tick(3);
    chk("rst_code_out", int'(bus.code_out), 0);
    chk("rst_code_valid", int'(bus.code_valid), 0);
    chk("rst_multi_err", int'(bus.multi_err), 0);
    chk("rst_timeout", int'(bus.timeout), 0);
    chk("rst_busy", int'(bus.busy), 0);
    rst = 1'b0;
    bus.enable = 1'b1;
    tick(5);

    // Basic single presses for every colour
    for (int i = 0; i < 4; i++) begin
      v0 = n_valid;
      bus.sw = pats[i];
      tick(10);
      chk($sformatf("held_busy_%0d", i), int'(bus.busy), 1);
      bus.sw = 4'b0000;
      rr = cyc;
      tick(10);
      lat = last_valid_cyc - rr;
      chk($sformatf("basic_count_%0d", i), n_valid - v0, 1);
      chk($sformatf("basic_code_%0d", i), int'(bus.code_out), codes[i]);
      chk($sformatf("basic_lat_ok_%0d", i), int'(lat >= 4 && lat <= 6), 1);
    end

    // Single-cycle glitch alone
    v0 = n_valid; m0 = n_merr;
    bus.sw = 4'b0100;
    tick(1);
    bus.sw = 4'b0000;
    tick(10);
    chk("glitch_valid", n_valid - v0, 0);
    chk("glitch_merr", n_merr - m0, 0);
    chk("glitch_code_hold", int'(bus.code_out), 3);

    // Bouncing press then a steady hold
    v0 = n_valid;
    for (int k = 0; k < 6; k++) begin
      bus.sw = (k % 2 == 0) ? 4'b0100 : 4'b0000;
      tick(1);
    end
    press_release(4'b0100, 10, lat);
    chk("bounce_count", n_valid - v0, 1);
    chk("bounce_code", int'(bus.code_out), 2);

    // Multi-hot press, then a valid press afterwards
    v0 = n_valid; m0 = n_merr;
    press_release(4'b0101, 10, lat);
    chk("multi_merr", n_merr - m0, 1);
    chk("multi_no_valid", n_valid - v0, 0);
    press_release(4'b0010, 10, lat);
    chk("after_multi_count", n_valid - v0, 1);
    chk("after_multi_code", int'(bus.code_out), 1);

    // Abort while held
    v0 = n_valid; m0 = n_merr;
    bus.sw = 4'b1000;
    tick(10);
    chk("abort_pre_busy", int'(bus.busy), 1);
    bus.enable = 1'b0;
    tick(1);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_valid", int'(bus.code_valid), 0);
    chk("abort_merr", int'(bus.multi_err), 0);
    chk("abort_code_hold", int'(bus.code_out), 1);
    bus.enable = 1'b1;
    tick(5);
    bus.sw = 4'b0000;
    tick(10);
    chk("abort_release_no_valid", n_valid - v0, 0);
    chk("abort_release_no_merr", n_merr - m0, 0);

    // Switch already on when enable rises
    v0 = n_valid;
    bus.enable = 1'b0;
    bus.sw = 4'b1000;
    tick(5);
    bus.enable = 1'b1;
    tick(20);
    chk("stuck_busy", int'(bus.busy), 0);
    bus.sw = 4'b0000;
    tick(10);
    chk("stuck_release_no_valid", n_valid - v0, 0);
    press_release(4'b0001, 10, lat);
    chk("stuck_fresh_count", n_valid - v0, 1);
    chk("stuck_fresh_code", int'(bus.code_out), 0);

    // Reset asserted while debouncing the release
    press_release(4'b1000, 10, lat);
    chk("pre_reset_code", int'(bus.code_out), 3);
    v0 = n_valid;
    bus.sw = 4'b0100;
    tick(10);
    bus.sw = 4'b0000;
    tick(3);
    chk("deb_rel_busy", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_code", int'(bus.code_out), 0);
    chk("async_rst_busy", int'(bus.busy), 0);
    chk("async_rst_valid", int'(bus.code_valid), 0);
    tick(2);
    rst = 1'b0;
    rr = cyc;
    tick(15);
    chk("post_reset_no_valid", n_valid - v0, 0);
    chk("no_timeout_before", n_tout, 0);

    // Idle player: timeout from reset release, then again after re-arm
    t0 = n_tout;
    while (n_tout == t0 && (cyc - rr) < 90) tick(1);
    chk("tout_first_count", n_tout - t0, 1);
    lat = last_tout_cyc - rr;
    chk("tout_first_lat_ok", int'(lat >= 50 && lat <= 56), 1);
    ref_cyc = last_tout_cyc;
    t0 = n_tout;
    while (n_tout == t0 && (cyc - ref_cyc) < 90) tick(1);
    chk("tout_second_count", n_tout - t0, 1);
    lat = last_tout_cyc - ref_cyc;
    chk("tout_rearm_lat_ok", int'(lat >= 50 && lat <= 56), 1);
    chk("tout_no_valid", n_valid - v0, 0);

    tick(2);
    chk("pulse_exclusive", n_excl, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/switch_input_capture.md
Name: switch_input_capture

Overview:
- Front-end stage directly upstream of the simonSays FSM's acceptInput/validateInput states.
- Synchronises and debounces the four player switches SW[3:0] and commits exactly one press per press/release cycle.
- Encodes the committed press to the 2-bit colour code used in sequence memory; it is the inverse of decoder_2_4.
- Flags multi-switch presses and player inactivity timeout to the FSM.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised cycles required to accept a level change (20 ms at 50 MHz); benches override to 2.
- TIMEOUT_CYCLES, 250000000, cycles allowed in WAIT_PRESS before timeout (5 s); benches override to 50.

Ports:
- CLOCK_50  input  1  system clock.
- reset  input  1  asynchronous, active-high reset; top drives ~KEY[0].
- enable  input  1  high while the FSM is in acceptInput; low aborts capture.
- sw  input  4  raw switch levels SW[3:0], asynchronous to CLOCK_50.
- code_out  output  2  committed colour code; holds its value until the next commit.
- code_valid  output  1  one-cycle pulse when code_out is updated.
- multi_err  output  1  one-cycle pulse when a debounced press has more than one bit set.
- timeout  output  1  one-cycle pulse when the player is idle for TIMEOUT_CYCLES.
- busy  output  1  high in every state except ARM and WAIT_PRESS.

Behaviour:
- Reset values: code_out = 0; code_valid, multi_err, timeout and busy = 0; state = ARM; all counters = 0.
- Synchroniser: two flops on sw produce sw_s, giving 2 cycles of latency. All decisions use sw_s.
- Debounce counter: clears whenever sw_s differs from the previous cycle. Otherwise it increments while below DEBOUNCE_CYCLES. "Stable" means the counter has reached DEBOUNCE_CYCLES.
- Encoding: 0001->0, 0010->1, 0100->2, 1000->3.
- FSM states, with transitions evaluated each clock:
  - ARM: wait for stable sw_s==0, then go to WAIT_PRESS. A switch left on from the previous round is never counted.
  - WAIT_PRESS: the timeout counter runs. Nonzero sw_s goes to DEB_PRESS and clears the timeout counter. Reaching TIMEOUT_CYCLES-1 pulses timeout and goes to ARM.
  - DEB_PRESS: if sw_s returns to 0 before it is stable (a glitch), go back to WAIT_PRESS. When stable nonzero:
    - one-hot value: latch it into press_q and go to HELD;
    - multi-hot value: pulse multi_err and go to ARM.
  - HELD: wait for sw_s==0, then go to DEB_REL. A change to a different nonzero pattern while held pulses multi_err and goes to ARM.
  - DEB_REL: when sw_s is stable 0, load code_out with encode(press_q), pulse code_valid, and go to WAIT_PRESS. Nonzero sw_s before stable returns to HELD.
- Commit on release: holding a switch produces exactly one code_valid.
- Latency: code_valid rises 2 + DEBOUNCE_CYCLES + 1 cycles (±1) after the release edge on sw.
- enable low: in any state, the next clock goes to ARM and clears counters. No pulses are emitted in that cycle, and code_out keeps its value.
- Pulse exclusivity: at most one of code_valid, multi_err and timeout is high in any cycle.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- Asynchronous reset mid-press: returns immediately to reset values. No pulse is emitted after reset is released until a full press/release completes.

Decomposition:
- Shared package simon_pkg: enum capture_state_t {ARM, WAIT_PRESS, DEB_PRESS, HELD, DEB_REL}; constant one-hot patterns SW_C0..SW_C3; function encode_onehot(logic[3:0]) returning logic[1:0].
- One sub-module, sync_debounce: the 2-flop synchroniser plus stability counter, parameterised by width and DEBOUNCE_CYCLES, with outputs sw_s and stable.

Test Plan:
- Basic press (DEBOUNCE_CYCLES=2, enable=1): sw=0100 for 10 cycles, then 0000 -> exactly one code_valid with code_out=2 within 6 cycles of release; repeat for 0001, 0010, 1000 -> 0, 1, 3.
- Bounce: sw toggles 0100/0000 every cycle for 6 cycles, then steady 0100 for 10 cycles, then release -> exactly one code_valid, code_out=2. A single-cycle glitch alone gives no pulse.
- Multi-hot: sw=0101 for 10 cycles -> one multi_err pulse, no code_valid; the next valid press after release still commits correctly.
- Timeout (TIMEOUT_CYCLES=50): enable=1 with sw=0 -> timeout pulses once, 50±3 cycles after entering WAIT_PRESS, and re-arms.
- Abort and reset: enable drops while in HELD -> state is ARM the next cycle with no pulses and code_out unchanged; reset asserted mid-DEB_REL -> all outputs 0 and the following release produces no code_valid.
- Stuck switch: sw=1000 already on when enable rises -> no commit until sw goes to 0 stably and a fresh press/release occurs.
